mem_word_ctrl: RTL
==================

Name: mem_word_ctrl

Overview:
Parametrised, word-organised on-chip memory. It is the next generation of the fixed 16-byte, 32-bit mem32 store.
- Byte-addressed interface with alignment checking and per-byte write enables.
- Registered single-cycle read latency with a valid strobe.
- Self-clearing of the whole array after reset.
- Sits behind the core's load/store path as a scratch data memory; replaces the high-impedance output with a defined error flag.

Parameters:
DATA_W, 32, word width in bits; multiple of 8, minimum 8.
ADDR_W, 4, byte-address width.
Derived constants (not overridable):
- NB = DATA_W/8, bytes per word.
- OFF_W = clog2(NB), byte-offset bits.
- DEPTH = 2**(ADDR_W-OFF_W), words.

Ports:
Clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr  input  1  write request.
rd  input  1  read request.
in_add  input  ADDR_W  byte address; must be word-aligned.
byte_en  input  NB  per-byte write enable; bit i covers data_in[8i+7:8i].
data_in  input  DATA_W  write data.
data_out  output  DATA_W  read data, registered.
valid  output  1  one-cycle pulse; data_out holds a successful read.
err  output  1  one-cycle pulse; previous-cycle request rejected.
ready  output  1  high when requests are accepted.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, valid=0, err=0, ready=0, state=INIT, init counter=0. Array contents are not reset asynchronously.
- State machine has two states, INIT and IDLE.
- INIT:
  - Each cycle, writes all-zero to word[cnt] and increments cnt.
  - After word DEPTH-1 is written, goes to IDLE; ready rises on that edge. Total is exactly DEPTH cycles after rst_n deasserts.
  - wr/rd are ignored: no err, no valid, no array change.
- IDLE: a request is accepted in any cycle with ready=1 and (wr or rd). ready stays 1.
- Request checks, evaluated in this order:
  1. wr and rd both high: rejected. No write, err=1 next cycle, valid=0, data_out holds.
  2. in_add[OFF_W-1:0] != 0 (misaligned): rejected. No write, err=1 next cycle, valid=0, data_out cleared to 0.
  3. Write: the word at in_add[ADDR_W-1:OFF_W] takes data_in only on lanes with byte_en=1 at the accepting edge. Other lanes are unchanged. byte_en=0 is a legal no-op write. No valid, no err.
  4. Read: data_out = word[index] at the next edge (latency 1). valid=1 for that one cycle.
- After a valid/err cycle, both outputs return to 0 unless a new request is accepted. data_out holds its last value otherwise.
- Back-to-back: one request per cycle, no bubbles.
- Write to address A followed next cycle by a read of A returns the new data (write-then-read ordering).
- Address wrap: every aligned in_add maps to a word, since DEPTH covers the full ADDR_W space; there is no out-of-range case.
- Reset mid-operation: an in-flight read's valid is dropped, the FSM re-enters INIT, and the array is fully re-cleared before ready returns.
- valid and err are never high in the same cycle.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {INIT, IDLE};
  - clog2-based constant functions for OFF_W/DEPTH;
  - response-code constants.
- One sub-module: mem_word_array, DEPTH x DATA_W storage with one byte-enabled synchronous write port and one synchronous read port.
- FSM, request checks and output registers live in mem_word_ctrl.

Test Plan:
Default parameters (DATA_W=32, ADDR_W=4, 4 words):
1. Release rst_n, hold rd=1 at in_add=0 throughout → ready=0 and no valid for 4 cycles; ready=1 in cycle 5; first read returns 00000000 with valid=1.
2. Write DEADBEEF at 0 with byte_en=1111, then write CAFEBABE at 4 and 12345678 at C in consecutive cycles; read 0, 4, C back-to-back → DEADBEEF, CAFEBABE, 12345678, valid=1 on three consecutive cycles.
3. Write 11223344 at 8, then 0000CAFE at 8 with byte_en=0011; read 8 → 1122CAFE.
4. Read at 0xE (misaligned) → next cycle err=1, valid=0, data_out=00000000. Write 0xE with data FFFFFFFF → err=1; a later read of C still returns 12345678.
5. wr=1 and rd=1 at 0 → err=1, valid=0, data_out unchanged; a later read of 0 is unchanged.
6. Assert rst_n low for 1 cycle during a read of 0 → valid stays 0, ready=0 for 4 cycles, then a read of 0 returns 00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the word-organised scratch memory.
// Includes the FSM state type, sizing helpers and the internal response codes.
package mem_pkg;

  typedef enum logic {INIT, IDLE} state_t;

  localparam int unsigned RESP_W = 2;
  localparam logic [RESP_W-1:0] RESP_NONE  = 2'd0;
  localparam logic [RESP_W-1:0] RESP_WRITE = 2'd1;
  localparam logic [RESP_W-1:0] RESP_READ  = 2'd2;
  localparam logic [RESP_W-1:0] RESP_ERR   = 2'd3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Byte-offset bits inside one word.
  function automatic int unsigned off_w(input int unsigned data_w);
    return clog2(data_w / 8);
  endfunction

  // Word count covering the whole byte-address space.
  function automatic int unsigned depth(input int unsigned data_w, input int unsigned addr_w);
    return 32'd1 << (addr_w - off_w(data_w));
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x DATA_W storage: one byte-enabled synchronous write port and one
// synchronous read port whose output register can be cleared.
module mem_word_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 32'd1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset; the controller clears it word by word instead.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_word_ctrl.sv
// Word-organised scratch memory: post-reset clearing, request checking and
// registered read/error responses around a byte-enabled word array.
module mem_word_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                Clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   in_add,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid,
  output logic                err,
  output logic                ready
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = off_w(DATA_W);
  localparam int unsigned DEPTH = depth(DATA_W, ADDR_W);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;

  state_t              state;
  logic [IDX_W-1:0]    cnt;

  logic [RESP_W-1:0]   resp_c;
  logic                mis_c;
  logic                clr_c;
  logic [IDX_W-1:0]    idx_c;
  logic                arr_we_c;
  logic [IDX_W-1:0]    arr_waddr_c;
  logic [NB-1:0]       arr_be_c;
  logic [DATA_W-1:0]   arr_wdata_c;

  assign mis_c = |(in_add & ADDR_W'(NB - 1));
  assign idx_c = in_add[ADDR_W-1:OFF_W];

  // Request classification; conflict beats misalignment, write beats read.
  always_comb begin
    resp_c = RESP_NONE;
    clr_c  = 1'b0;
    if (state == IDLE && (wr || rd)) begin
      if (wr && rd) begin
        resp_c = RESP_ERR;
      end else if (mis_c) begin
        resp_c = RESP_ERR;
        clr_c  = 1'b1;
      end else if (wr) begin
        resp_c = RESP_WRITE;
      end else begin
        resp_c = RESP_READ;
      end
    end
  end

  // Write port is shared between the clearing sweep and accepted writes.
  always_comb begin
    arr_we_c    = 1'b0;
    arr_waddr_c = idx_c;
    arr_be_c    = byte_en;
    arr_wdata_c = data_in;
    if (state == INIT) begin
      arr_we_c    = 1'b1;
      arr_waddr_c = cnt;
      arr_be_c    = '1;
      arr_wdata_c = '0;
    end else if (resp_c == RESP_WRITE) begin
      arr_we_c = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      ready <= 1'b0;
    end else begin
      valid <= (resp_c == RESP_READ);
      err   <= (resp_c == RESP_ERR);
      case (state)
        INIT: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  mem_word_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (Clk),
    .rst_n (rst_n),
    .we    (arr_we_c),
    .waddr (arr_waddr_c),
    .be    (arr_be_c),
    .wdata (arr_wdata_c),
    .re    (resp_c == RESP_READ),
    .clr   (clr_c),
    .raddr (idx_c),
    .rdata (data_out)
  );

endmodule
